// File: rtl/penguen_skor_tablosu.sv
// Multi-round scoreboard fed by the five-penguin round evaluator: captures one result per
// bitti high period and keeps win/loss counters, round count, all-time record and an error flag.
module penguen_skor_tablosu #(
    parameter int unsigned SAYAC_W = 4,
    parameter int unsigned TUR_W   = 8
) (
    input  logic               saat_i,
    input  logic               reset_i,
    input  logic               bitti_i,
    input  logic [2:0]         hizli_penguen_i,
    input  logic [2:0]         yavas_penguen_i,
    input  logic [6:0]         en_kisa_i,
    input  logic [6:0]         ortalama_i,
    input  logic [2:0]         sorgu_no_i,
    input  logic               sorgu_gecerli_i,
    output logic [TUR_W-1:0]   tur_sayisi_o,
    output logic [6:0]         rekor_sure_o,
    output logic [2:0]         rekor_sahibi_o,
    output logic [6:0]         son_ortalama_o,
    output logic               guncelleme_o,
    output logic [SAYAC_W-1:0] sorgu_galibiyet_o,
    output logic [SAYAC_W-1:0] sorgu_maglubiyet_o,
    output logic               sorgu_hazir_o,
    output logic               hata_o
);

    typedef enum logic [1:0] {StBekle, StGuncelle, StSerbest} durum_e;

    localparam logic [SAYAC_W-1:0] SayacMax = {SAYAC_W{1'b1}};
    localparam logic [TUR_W-1:0]   TurMax   = {TUR_W{1'b1}};

    durum_e durum_q, durum_d;

    logic [2:0] hizli_q, hizli_d;
    logic [2:0] yavas_q, yavas_d;
    logic [6:0] en_kisa_q, en_kisa_d;
    logic [6:0] ortalama_q, ortalama_d;

    logic [SAYAC_W-1:0] galibiyet_q [5];
    logic [SAYAC_W-1:0] galibiyet_d [5];
    logic [SAYAC_W-1:0] maglubiyet_q [5];
    logic [SAYAC_W-1:0] maglubiyet_d [5];

    logic [TUR_W-1:0]   tur_q, tur_d;
    logic [6:0]         rekor_sure_q, rekor_sure_d;
    logic [2:0]         rekor_sahibi_q, rekor_sahibi_d;
    logic               rekor_gecerli_q, rekor_gecerli_d;
    logic [6:0]         son_ort_q, son_ort_d;
    logic               guncelleme_q, guncelleme_d;
    logic [SAYAC_W-1:0] sorgu_gal_q, sorgu_gal_d;
    logic [SAYAC_W-1:0] sorgu_mag_q, sorgu_mag_d;
    logic               sorgu_hazir_q, sorgu_hazir_d;
    logic               hata_q, hata_d;

    logic hizli_ok, yavas_ok, sorgu_ok;

    function automatic logic gecerli(input logic [2:0] p);
        return (p >= 3'd1) && (p <= 3'd5);
    endfunction

    always_comb begin
        hizli_ok = gecerli(hizli_q);
        yavas_ok = gecerli(yavas_q);
        sorgu_ok = gecerli(sorgu_no_i);
    end

    always_comb begin
        durum_d         = durum_q;
        hizli_d         = hizli_q;
        yavas_d         = yavas_q;
        en_kisa_d       = en_kisa_q;
        ortalama_d      = ortalama_q;
        galibiyet_d     = galibiyet_q;
        maglubiyet_d    = maglubiyet_q;
        tur_d           = tur_q;
        rekor_sure_d    = rekor_sure_q;
        rekor_sahibi_d  = rekor_sahibi_q;
        rekor_gecerli_d = rekor_gecerli_q;
        son_ort_d       = son_ort_q;
        guncelleme_d    = 1'b0;
        hata_d          = hata_q;

        unique case (durum_q)
            StBekle: begin
                if (bitti_i) begin
                    hizli_d    = hizli_penguen_i;
                    yavas_d    = yavas_penguen_i;
                    en_kisa_d  = en_kisa_i;
                    ortalama_d = ortalama_i;
                    durum_d    = StGuncelle;
                end
            end
            StGuncelle: begin
                if (tur_q != TurMax) begin
                    tur_d = tur_q + 1'b1;
                end
                // Invalid indices match no slot, so only the valid side's counter moves.
                for (int i = 0; i < 5; i++) begin
                    if (hizli_ok && hizli_q == 3'(i + 1) && galibiyet_q[i] != SayacMax) begin
                        galibiyet_d[i] = galibiyet_q[i] + 1'b1;
                    end
                    if (yavas_ok && yavas_q == 3'(i + 1) && maglubiyet_q[i] != SayacMax) begin
                        maglubiyet_d[i] = maglubiyet_q[i] + 1'b1;
                    end
                end
                son_ort_d = ortalama_q;
                // Strict compare: a tie leaves the earlier holder in place.
                if (hizli_ok && (!rekor_gecerli_q || en_kisa_q < rekor_sure_q)) begin
                    rekor_sure_d    = en_kisa_q;
                    rekor_sahibi_d  = hizli_q;
                    rekor_gecerli_d = 1'b1;
                end
                if (!hizli_ok || !yavas_ok) begin
                    hata_d = 1'b1;
                end
                guncelleme_d = 1'b1;
                durum_d      = StSerbest;
            end
            StSerbest: begin
                if (!bitti_i) begin
                    durum_d = StBekle;
                end
            end
            default: durum_d = StSerbest;
        endcase
    end

    // Query reads the registered counters, so a same-edge update is not yet visible.
    always_comb begin
        sorgu_gal_d   = sorgu_gal_q;
        sorgu_mag_d   = sorgu_mag_q;
        sorgu_hazir_d = sorgu_gecerli_i;
        if (sorgu_gecerli_i) begin
            if (sorgu_ok) begin
                sorgu_gal_d = galibiyet_q[sorgu_no_i - 3'd1];
                sorgu_mag_d = maglubiyet_q[sorgu_no_i - 3'd1];
            end else begin
                sorgu_gal_d = '0;
                sorgu_mag_d = '0;
            end
        end
    end

    always_ff @(posedge saat_i) begin
        if (reset_i) begin
            durum_q         <= StSerbest;
            hizli_q         <= '0;
            yavas_q         <= '0;
            en_kisa_q       <= '0;
            ortalama_q      <= '0;
            galibiyet_q     <= '{default: '0};
            maglubiyet_q    <= '{default: '0};
            tur_q           <= '0;
            rekor_sure_q    <= '0;
            rekor_sahibi_q  <= '0;
            rekor_gecerli_q <= 1'b0;
            son_ort_q       <= '0;
            guncelleme_q    <= 1'b0;
            sorgu_gal_q     <= '0;
            sorgu_mag_q     <= '0;
            sorgu_hazir_q   <= 1'b0;
            hata_q          <= 1'b0;
        end else begin
            durum_q         <= durum_d;
            hizli_q         <= hizli_d;
            yavas_q         <= yavas_d;
            en_kisa_q       <= en_kisa_d;
            ortalama_q      <= ortalama_d;
            galibiyet_q     <= galibiyet_d;
            maglubiyet_q    <= maglubiyet_d;
            tur_q           <= tur_d;
            rekor_sure_q    <= rekor_sure_d;
            rekor_sahibi_q  <= rekor_sahibi_d;
            rekor_gecerli_q <= rekor_gecerli_d;
            son_ort_q       <= son_ort_d;
            guncelleme_q    <= guncelleme_d;
            sorgu_gal_q     <= sorgu_gal_d;
            sorgu_mag_q     <= sorgu_mag_d;
            sorgu_hazir_q   <= sorgu_hazir_d;
            hata_q          <= hata_d;
        end
    end

    assign tur_sayisi_o       = tur_q;
    assign rekor_sure_o       = rekor_sure_q;
    assign rekor_sahibi_o     = rekor_sahibi_q;
    assign son_ortalama_o     = son_ort_q;
    assign guncelleme_o       = guncelleme_q;
    assign sorgu_galibiyet_o  = sorgu_gal_q;
    assign sorgu_maglubiyet_o = sorgu_mag_q;
    assign sorgu_hazir_o      = sorgu_hazir_q;
    assign hata_o             = hata_q;

endmodule

// File: doc/penguen_skor_tablosu.md
Name: penguen_skor_tablosu

Overview:
- Downstream consumer of the five-penguin round evaluator.
- Each time the evaluator raises bitti, the block captures that round's result: fastest/slowest penguin index, shortest time and average.
- Keeps multi-round statistics: per-penguin win and loss counters, round count, all-time record time and record holder, plus a sticky error flag.
- Per-penguin counters are read through a registered query port.

Parameters:
- SAYAC_W, 4, width of each per-penguin win/loss counter (saturating).
- TUR_W, 8, width of the round counter (saturating).

Ports:
- saat  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- bitti  in  1  evaluator round-complete level.
- hizli_penguen  in  3  fastest penguin index, 1..5.
- yavas_penguen  in  3  slowest penguin index, 1..5.
- en_kisa  in  7  shortest finish time of the round.
- ortalama  in  7  average finish time of the round.
- sorgu_no  in  3  penguin index to query.
- sorgu_gecerli  in  1  query strobe.
- tur_sayisi  out  TUR_W  rounds recorded.
- rekor_sure  out  7  best en_kisa over all rounds.
- rekor_sahibi  out  3  penguin holding the record; 0 = none.
- son_ortalama  out  7  ortalama of the last recorded round.
- guncelleme  out  1  one-cycle pulse; updated statistics are visible.
- sorgu_galibiyet  out  SAYAC_W  win count of the queried penguin.
- sorgu_maglubiyet  out  SAYAC_W  loss count of the queried penguin.
- sorgu_hazir  out  1  one-cycle pulse; query outputs are valid.
- hata  out  1  sticky invalid-index flag.

Behaviour:
- Reset (synchronous, active-high) clears:
  - all outputs to 0;
  - all ten counters and the internal record-valid flag;
  - FSM goes to SERBEST, not BEKLE, so a bitti already high is never counted; bitti must be seen low first.
- FSM states: BEKLE, GUNCELLE, SERBEST.
  - BEKLE: at an edge with bitti=1, register hizli_penguen, yavas_penguen, en_kisa, ortalama into capture registers; go to GUNCELLE. Otherwise stay.
  - GUNCELLE: unconditionally, at the next edge, apply the update (below), set guncelleme<=1, go to SERBEST.
  - SERBEST: guncelleme<=0 at the first edge in this state. Stay while bitti=1; at an edge with bitti=0 go to BEKLE.
- Result: exactly one round is recorded per bitti high period, regardless of its length.
- Latency: bitti sampled at edge N -> statistics and guncelleme=1 visible in the cycle after edge N+1. guncelleme is high for exactly one cycle.
- Minimum round spacing: bitti must be low for at least one sampled edge between rounds.
- Update rules, all applied at the same edge:
  - Round counter: tur_sayisi+1, saturating at 2^TUR_W-1.
  - Win counter: galibiyet[hizli]+1, saturating at 2^SAYAC_W-1.
  - Loss counter: maglubiyet[yavas]+1, same saturation.
  - If hizli==yavas (all times equal), both counters of that penguin increment.
  - son_ortalama <= captured ortalama.
  - Record:
    - If no valid record, or captured en_kisa < rekor_sure strictly: rekor_sure <= en_kisa, rekor_sahibi <= hizli, record-valid <= 1.
    - On a tie, the earlier holder is kept.
- Invalid index (hizli or yavas in {0,6,7}):
  - The counter for that index is not touched; the other valid index still updates.
  - The round still counts.
  - The record is not updated if hizli is invalid.
  - hata <= 1, cleared only by reset.
- Query port:
  - At an edge with sorgu_gecerli=1, latch the counters for sorgu_no into sorgu_galibiyet and sorgu_maglubiyet; sorgu_hazir=1 for the following cycle only.
  - Values are those before any same-edge update. A query coinciding with the GUNCELLE edge returns pre-update counts.
  - sorgu_no outside 1..5 returns zeros with sorgu_hazir=1; hata is not affected.
  - Query outputs hold their value until the next query.
- Reset mid-round, including in GUNCELLE: the capture is discarded, nothing is recorded, and reset values apply.

Test Plan:
- Reset then bitti=1 held: no update; guncelleme stays 0 until bitti falls and rises again.
- Round: hizli=2, yavas=5, en_kisa=12, ortalama=20 -> two cycles after bitti sampled: tur_sayisi=1, rekor_sure=12, rekor_sahibi=2, son_ortalama=20, guncelleme pulse of 1 cycle; query 2 -> win=1, loss=0; query 5 -> win=0, loss=1.
- Second round en_kisa=12, hizli=3, then third round en_kisa=9, hizli=4 -> record holder stays 2 after the tie, then becomes 4 with rekor_sure=9; tur_sayisi=3.
- 16 rounds with hizli=1 (SAYAC_W=4) -> win counter of penguin 1 saturates at 15; tur_sayisi=16.
- Round with hizli=0, yavas=3 -> hata=1, loss[3]+1, no win counter change, record unchanged, tur_sayisi+1. Query sorgu_no=7 -> zeros with sorgu_hazir=1.
- bitti held high for 10 cycles -> single recorded round. Query strobed on the GUNCELLE edge returns the old count; re-query returns the new count. Reset asserted in GUNCELLE -> tur_sayisi=0, no guncelleme pulse.
